keyboard_mmio_port: RTL and testbench

Device-side responder for the keyboard memory-mapped registers KBSR (0xFE00) and KBDR (0xFE02), which the memory control unit decodes and forwards.
- Receives PS/2 keyboard frames and holds one scan-code byte in KBDR.
- Maintains ready, interrupt-enable and error status in KBSR.
- Answers CPU register reads and writes through the MIO strobe, and raises a keyboard interrupt request.

---
 rtl/elc3_mmio_pkg.sv | 13 +
 rtl/ps2_rx_frame.sv | 124 ++++++++++++
 rtl/keyboard_mmio_port.sv | 104 ++++++++++
 tb/tb_keyboard_mmio_port.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/elc3_mmio_pkg.sv
// Shared register addresses, KBSR bit positions and PS/2 receiver states
// for the keyboard MMIO port.
package elc3_mmio_pkg;
  localparam logic [15:0] KBSR_ADDR = 16'hFE00;
  localparam logic [15:0] KBDR_ADDR = 16'hFE02;

  localparam int KBSR_READY_BIT = 15;
  localparam int KBSR_IE_BIT    = 14;
  localparam int KBSR_OVR_BIT   = 13;
  localparam int KBSR_PERR_BIT  = 12;

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} ps2_state_t;
endpackage

// File: rtl/ps2_rx_frame.sv
// PS/2 frame receiver: byte_done pulses combinationally in the stop-bit sample cycle; no backpressure.
// KB_PARITY_CHECK_EN adds odd-parity checking and the parity_err pulse.
module ps2_rx_frame
  import elc3_mmio_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 50000,
  parameter int SYNC_STAGES    = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ps2_clk,
  input  logic       ps2_data,
`ifdef KB_PARITY_CHECK_EN
  output logic       parity_err,
`endif
  output logic       byte_done,
  output logic [7:0] byte_dat
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

  logic [SYNC_STAGES-1:0] clk_sync;
  logic [SYNC_STAGES-1:0] data_sync;
  logic                   clk_prev;
  logic                   fall;
  logic                   data_s;

  ps2_state_t  state_q, state_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic [7:0]  shift_q, shift_d;
  logic [TW-1:0] tmo_q, tmo_d;
`ifdef KB_PARITY_CHECK_EN
  logic        par_q, par_d;
`endif

  // Lines idle high, so synchronizers reset to 1 to avoid a false edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_sync  <= '1;
      data_sync <= '1;
      clk_prev  <= 1'b1;
    end else begin
      clk_sync  <= {clk_sync[SYNC_STAGES-2:0], ps2_clk};
      data_sync <= {data_sync[SYNC_STAGES-2:0], ps2_data};
      clk_prev  <= clk_sync[SYNC_STAGES-1];
    end
  end

  assign fall     = clk_prev & ~clk_sync[SYNC_STAGES-1];
  assign data_s   = data_sync[SYNC_STAGES-1];
  assign byte_dat = shift_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      tmo_q     <= '0;
`ifdef KB_PARITY_CHECK_EN
      par_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      tmo_q     <= tmo_d;
`ifdef KB_PARITY_CHECK_EN
      par_q     <= par_d;
`endif
    end
  end

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    tmo_d     = (state_q == IDLE) ? '0 : tmo_q + TW'(1);
    byte_done = 1'b0;
`ifdef KB_PARITY_CHECK_EN
    par_d      = par_q;
    parity_err = 1'b0;
`endif
    if (fall) begin
      tmo_d = '0;
      case (state_q)
        IDLE: begin
          if (!data_s) begin
            state_d   = DATA;
            bit_cnt_d = '0;
          end
        end
        DATA: begin
          // LSB arrives first; shifting in at the MSB leaves the byte aligned after 8 bits.
          shift_d   = {data_s, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) state_d = PARITY;
        end
        PARITY: begin
`ifdef KB_PARITY_CHECK_EN
          par_d = data_s;
`endif
          state_d = STOP;
        end
        STOP: begin
          state_d = IDLE;
          if (data_s) begin
`ifdef KB_PARITY_CHECK_EN
            if (^{shift_q, par_q}) byte_done  = 1'b1;
            else                   parity_err = 1'b1;
`else
            byte_done = 1'b1;
`endif
          end
        end
        default: state_d = IDLE;
      endcase
    end else if (state_q != IDLE && tmo_q == TMO_LAST) begin
      state_d = IDLE;
      tmo_d   = '0;
    end
  end

endmodule

// File: rtl/keyboard_mmio_port.sv
// KBSR/KBDR responder for a PS/2 keyboard; a received byte lands in KBDR 1 cycle after the stop-bit sample.
// No backpressure: a byte arriving while READY=1 is dropped and flagged OVERRUN; KB_PARITY_CHECK_EN adds PERR.
module keyboard_mmio_port
  import elc3_mmio_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 50000,
  parameter int SYNC_STAGES    = 2
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        PS2_Clk,
  input  logic        PS2_Data,
  input  logic        MIO_EN,
  input  logic        R_W,
  input  logic [15:0] Address,
  input  logic [15:0] Data_FromCPU,
  output logic [15:0] Data_ToCPU,
  output logic        Sel,
  output logic        KB_INT
);

  logic [7:0]  rx_byte;
  logic        byte_done;
  logic [7:0]  kbdr_q;
  logic        ready_q, ie_q, ovr_q;
  logic        rd_prev;
  logic        kbsr_hit, kbdr_hit;
  logic        kbdr_rd, rd_clr, kbsr_wr;
  logic [15:0] kbsr;
  logic        unused_wdat;
`ifdef KB_PARITY_CHECK_EN
  logic        parity_err;
  logic        perr_q;
`endif

  ps2_rx_frame #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
    .SYNC_STAGES   (SYNC_STAGES)
  ) u_rx (
    .clk       (Clk),
    .rst_n     (Reset),
    .ps2_clk   (PS2_Clk),
    .ps2_data  (PS2_Data),
`ifdef KB_PARITY_CHECK_EN
    .parity_err(parity_err),
`endif
    .byte_done (byte_done),
    .byte_dat  (rx_byte)
  );

  assign kbsr_hit = (Address == KBSR_ADDR);
  assign kbdr_hit = (Address == KBDR_ADDR);
  assign Sel      = kbsr_hit | kbdr_hit;

  assign kbdr_rd  = MIO_EN & ~R_W & kbdr_hit;
  // Only the first cycle of a held read clears READY.
  assign rd_clr   = kbdr_rd & ~rd_prev;
  assign kbsr_wr  = MIO_EN & R_W & kbsr_hit;

  assign unused_wdat = ^{Data_FromCPU[15], Data_FromCPU[13:0]};

  always_comb begin
    kbsr                 = '0;
    kbsr[KBSR_READY_BIT] = ready_q;
    kbsr[KBSR_IE_BIT]    = ie_q;
    kbsr[KBSR_OVR_BIT]   = ovr_q;
`ifdef KB_PARITY_CHECK_EN
    kbsr[KBSR_PERR_BIT]  = perr_q;
`endif
    if (kbsr_hit)      Data_ToCPU = kbsr;
    else if (kbdr_hit) Data_ToCPU = {8'h00, kbdr_q};
    else               Data_ToCPU = 16'h0000;
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      kbdr_q  <= '0;
      ready_q <= 1'b0;
      ie_q    <= 1'b0;
      ovr_q   <= 1'b0;
      rd_prev <= 1'b0;
      KB_INT  <= 1'b0;
`ifdef KB_PARITY_CHECK_EN
      perr_q  <= 1'b0;
`endif
    end else begin
      rd_prev <= kbdr_rd;
      KB_INT  <= ready_q & ie_q;
      // A read clearing READY in the same cycle frees the slot for the new byte.
      if (byte_done && (!ready_q || rd_clr)) begin
        kbdr_q  <= rx_byte;
        ready_q <= 1'b1;
      end else if (rd_clr) begin
        ready_q <= 1'b0;
      end
      if (kbsr_wr) ie_q <= Data_FromCPU[KBSR_IE_BIT];
      ovr_q <= (ovr_q & ~kbsr_wr) | (byte_done & ready_q & ~rd_clr);
`ifdef KB_PARITY_CHECK_EN
      perr_q <= (perr_q & ~kbsr_wr) | parity_err;
`endif
    end
  end

endmodule

// File: tb/tb_keyboard_mmio_port.sv
// Bench for keyboard_mmio_port: register decode table, directed PS/2 corner cases,
// and random traffic against a transaction-level model of KBSR/KBDR.
module tb_keyboard_mmio_port;
  localparam int TMO = 300;
  localparam logic [15:0] SR = 16'hFE00;
  localparam logic [15:0] DR = 16'hFE02;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ps2_clk, ps2_data;
  logic        mio_en, r_w;
  logic [15:0] address, wdat;
  logic [15:0] rdat;
  logic        sel, kb_int;

  int n_vec = 0;
  int n_err = 0;

  // Reference model of the visible registers
  logic       m_ready, m_ie, m_ovr, m_perr;
  logic [7:0] m_kbdr;

  keyboard_mmio_port #(.TIMEOUT_CYCLES(TMO), .SYNC_STAGES(2)) dut (
    .Clk(clk), .Reset(rst_n), .PS2_Clk(ps2_clk), .PS2_Data(ps2_data),
    .MIO_EN(mio_en), .R_W(r_w), .Address(address), .Data_FromCPU(wdat),
    .Data_ToCPU(rdat), .Sel(sel), .KB_INT(kb_int)
  );

  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, got no summary, required completion");
    $fatal(1);
  end

  typedef struct {
    logic mio; logic rw; logic [15:0] addr; logic [15:0] wd;
    logic [15:0] exp_rd; logic exp_sel;
  } vec_t;
  vec_t vt[12];

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_regs(input string tag, input logic [15:0] e_sr, input logic [15:0] e_dr, input logic e_int);
    mio_en = 1'b0; r_w = 1'b0;
    address = SR; #1;
    chk({tag, ".kbsr"}, rdat, e_sr);
    address = DR; #1;
    chk({tag, ".kbdr"}, rdat, e_dr);
    chk({tag, ".kb_int"}, 16'(kb_int), 16'(e_int));
  endtask

  function automatic logic [10:0] mkframe(input logic [7:0] v, input logic badpar, input logic badstop);
    logic p;
    p = (~^v) ^ badpar;
    return {~badstop, p, v, 1'b0};
  endfunction

  task automatic send_bits(input logic [10:0] f, input int n, input int h);
    for (int i = 0; i < n; i++) begin
      ps2_data = f[i]; ps2_clk = 1'b1; cyc(h);
      ps2_clk = 1'b0; cyc(h);
    end
  endtask

  // Sends a good frame and reports the cycle (counted from the stop-bit clock fall)
  // at which READY and KB_INT first appear, -1 if never.
  task automatic send_watch(input logic [7:0] v, output int rdy_at, output int int_at);
    logic [10:0] f;
    f = mkframe(v, 1'b0, 1'b0);
    send_bits(f, 10, 4);
    ps2_data = 1'b1; ps2_clk = 1'b1; cyc(4);
    ps2_clk = 1'b0; mio_en = 1'b0; address = SR;
    rdy_at = -1; int_at = -1;
    for (int k = 1; k <= 6; k++) begin
      cyc(1);
      if (rdy_at < 0 && rdat[15]) rdy_at = k;
      if (int_at < 0 && kb_int) int_at = k;
    end
    ps2_clk = 1'b1; cyc(2);
  endtask

  task automatic send_frame(input logic [7:0] v, input logic badpar, input logic badstop, input int h);
    send_bits(mkframe(v, badpar, badstop), 11, h);
    ps2_clk = 1'b1; cyc(2);
  endtask

  task automatic cpu_read(input int hold);
    mio_en = 1'b1; r_w = 1'b0; address = DR; cyc(hold);
    mio_en = 1'b0; cyc(1);
  endtask

  task automatic cpu_write(input logic [15:0] d);
    mio_en = 1'b1; r_w = 1'b1; address = SR; wdat = d; cyc(1);
    mio_en = 1'b0; r_w = 1'b0; cyc(1);
  endtask

  task automatic m_deliver(input logic [7:0] v);
    if (!m_ready) begin m_kbdr = v; m_ready = 1'b1; end
    else m_ovr = 1'b1;
  endtask

  function automatic logic [15:0] m_kbsr();
    return {m_ready, m_ie, m_ovr, m_perr, 12'h000};
  endfunction

  initial begin
    int ra, ia;
    vt[0]  = '{1'b0, 1'b0, SR,       16'h0000, 16'h0000, 1'b1};
    vt[1]  = '{1'b0, 1'b0, DR,       16'h0000, 16'h0000, 1'b1};
    vt[2]  = '{1'b1, 1'b0, DR,       16'h0000, 16'h0000, 1'b1};
    vt[3]  = '{1'b0, 1'b0, 16'hFE01, 16'h0000, 16'h0000, 1'b0};
    vt[4]  = '{1'b0, 1'b0, 16'hFE03, 16'h0000, 16'h0000, 1'b0};
    vt[5]  = '{1'b0, 1'b0, 16'h7E00, 16'h0000, 16'h0000, 1'b0};
    vt[6]  = '{1'b1, 1'b1, DR,       16'hFFFF, 16'h0000, 1'b1};
    vt[7]  = '{1'b0, 1'b0, SR,       16'h0000, 16'h0000, 1'b1};
    vt[8]  = '{1'b1, 1'b1, SR,       16'h4000, 16'h0000, 1'b1};
    vt[9]  = '{1'b0, 1'b0, SR,       16'h0000, 16'h4000, 1'b1};
    vt[10] = '{1'b1, 1'b1, SR,       16'hBFFF, 16'h4000, 1'b1};
    vt[11] = '{1'b0, 1'b0, SR,       16'h0000, 16'h0000, 1'b1};

    rst_n = 1'b0; ps2_clk = 1'b1; ps2_data = 1'b1;
    mio_en = 1'b0; r_w = 1'b0; address = SR; wdat = 16'h0000;
    cyc(3);
    check_regs("reset", 16'h0000, 16'h0000, 1'b0);
    rst_n = 1'b1;
    cyc(2);

    for (int i = 0; i < 12; i++) begin
      mio_en = vt[i].mio; r_w = vt[i].rw; address = vt[i].addr; wdat = vt[i].wd;
      #1;
      chk($sformatf("tbl%0d.rd", i), rdat, vt[i].exp_rd);
      chk($sformatf("tbl%0d.sel", i), 16'(sel), 16'(vt[i].exp_sel));
      chk($sformatf("tbl%0d.int", i), 16'(kb_int), 16'h0000);
      cyc(1);
    end
    mio_en = 1'b0; r_w = 1'b0; cyc(1);

    // Basic receive with exact latency, then read-clear
    send_watch(8'h1C, ra, ia);
    chk("a.ready_lat", 16'(ra), 16'd3);
    chk("a.no_int", 16'(ia), 16'hFFFF);
    check_regs("a.rx", 16'h8000, 16'h001C, 1'b0);
    mio_en = 1'b1; r_w = 1'b0; address = DR; #1;
    chk("a.rd_data", rdat, 16'h001C);
    cyc(1); mio_en = 1'b0; cyc(1);
    check_regs("a.after_rd", 16'h0000, 16'h001C, 1'b0);

    // Interrupt timing
    cpu_write(16'h4000);
    send_watch(8'h5A, ra, ia);
    chk("b.ready_lat", 16'(ra), 16'd3);
    chk("b.int_lat", 16'(ia), 16'd4);
    check_regs("b.rx", 16'hC000, 16'h005A, 1'b1);
    mio_en = 1'b1; r_w = 1'b0; address = DR; cyc(1);
    mio_en = 1'b0; address = SR; #1;
    chk("b.sr_after_rd", rdat, 16'h4000);
    chk("b.int_lags", 16'(kb_int), 16'h0001);
    cyc(1);
    chk("b.int_clr", 16'(kb_int), 16'h0000);
    cpu_write(16'h0000);

    // Overrun
    send_frame(8'h1C, 1'b0, 1'b0, 4);
    send_frame(8'h32, 1'b0, 1'b0, 4);
    check_regs("c.ovr", 16'hA000, 16'h001C, 1'b0);
    cpu_write(16'h0000);
    check_regs("c.clr", 16'h8000, 16'h001C, 1'b0);

    // Read clear coincident with byte_done
    send_bits(mkframe(8'h45, 1'b0, 1'b0), 10, 4);
    ps2_data = 1'b1; ps2_clk = 1'b1; cyc(4);
    ps2_clk = 1'b0; cyc(2);
    mio_en = 1'b1; r_w = 1'b0; address = DR; #1;
    chk("d1.pre_clear", rdat, 16'h001C);
    cyc(1);
    mio_en = 1'b0; #1;
    chk("d1.new_byte", rdat, 16'h0045);
    cyc(1); ps2_clk = 1'b1; cyc(2);
    check_regs("d1", 16'h8000, 16'h0045, 1'b0);

    // Held read clears READY once; byte landing mid-hold survives
    send_bits(mkframe(8'h16, 1'b0, 1'b0), 10, 4);
    ps2_data = 1'b1; ps2_clk = 1'b1; cyc(4);
    ps2_clk = 1'b0; cyc(1);
    mio_en = 1'b1; r_w = 1'b0; address = DR; #1;
    chk("d2.pre_clear", rdat, 16'h0045);
    cyc(3);
    mio_en = 1'b0; ps2_clk = 1'b1; cyc(2);
    check_regs("d2", 16'h8000, 16'h0016, 1'b0);
    cpu_read(1);

    // Abandoned partial frame
    send_bits(mkframe(8'h77, 1'b0, 1'b0), 5, 4);
    ps2_clk = 1'b1; cyc(TMO + 20);
    check_regs("e.partial", 16'h0000, 16'h0016, 1'b0);
    send_frame(8'h29, 1'b0, 1'b0, 4);
    check_regs("e.resync", 16'h8000, 16'h0029, 1'b0);
    cpu_read(1);

    // Corrupted parity
    send_frame(8'h3A, 1'b1, 1'b0, 4);
`ifdef KB_PARITY_CHECK_EN
    check_regs("f.perr", 16'h1000, 16'h0029, 1'b0);
    cpu_write(16'h0000);
    check_regs("f.clr", 16'h0000, 16'h0029, 1'b0);
    m_kbdr = 8'h29;
`else
    check_regs("f.noperr", 16'h8000, 16'h003A, 1'b0);
    cpu_read(1);
    m_kbdr = 8'h3A;
`endif
    // Bad stop bit is discarded silently
    send_frame(8'h11, 1'b0, 1'b1, 4);
    check_regs("f.badstop", 16'h0000, {8'h00, m_kbdr}, 1'b0);

    m_ready = 1'b0; m_ie = 1'b0; m_ovr = 1'b0; m_perr = 1'b0;
    for (int t = 0; t < 40; t++) begin
      int op;
      op = $urandom_range(9, 0);
      if (op <= 4) begin
        logic [7:0] v;
        int kind;
        v = 8'($urandom_range(255, 0));
        kind = $urandom_range(4, 0);
        send_frame(v, kind == 3, kind == 4, $urandom_range(6, 3));
        if (kind == 4) begin
        end else if (kind == 3) begin
`ifdef KB_PARITY_CHECK_EN
          m_perr = 1'b1;
`else
          m_deliver(v);
`endif
        end else begin
          m_deliver(v);
        end
      end else if (op <= 6) begin
        mio_en = 1'b1; r_w = 1'b0; address = DR; #1;
        chk($sformatf("rnd%0d.rd", t), rdat, {8'h00, m_kbdr});
        cyc($urandom_range(3, 1));
        mio_en = 1'b0; m_ready = 1'b0;
      end else if (op <= 8) begin
        logic [15:0] d;
        d = 16'($urandom);
        cpu_write(d);
        m_ie = d[14]; m_ovr = 1'b0; m_perr = 1'b0;
      end
      cyc(3);
      check_regs($sformatf("rnd%0d", t), m_kbsr(), {8'h00, m_kbdr}, m_ready & m_ie);
    end

    // Reset in the middle of a frame
    cpu_read(1);
    cpu_write(16'h4000);
    send_frame(8'h6B, 1'b0, 1'b0, 4);
    cyc(2);
    check_regs("g.pre", 16'hC000, 16'h006B, 1'b1);
    send_bits(mkframe(8'h5D, 1'b0, 1'b0), 5, 4);
    rst_n = 1'b0;
    check_regs("g.async_rst", 16'h0000, 16'h0000, 1'b0);
    ps2_clk = 1'b1; cyc(2);
    rst_n = 1'b1; cyc(TMO + 20);
    check_regs("g.post", 16'h0000, 16'h0000, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
